sram_1rw1r_param: RTL and testbench

Parametrised dual-port SRAM behavioural model: port 0 is read/write with a per-byte write mask, port 1 is read-only. Both ports share one clock. All inputs are registered, and the model has a two-stage read pipeline with per-port read-valid strobes. A hardware clear sequencer zeroes the whole array after every reset. It replaces the fixed 8x64 single-port macro anywhere the datapath needs a concurrent read port, wider words or a known-zero memory.

---
 rtl/sram_1rw1r_param.sv | 125 ++++++++++++
 tb/tb_sram_1rw1r_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_param.sv
// Dual-port SRAM model: port 0 read/write with byte mask, port 1 read-only.
// Two-stage pipeline (register request, then access) plus a post-reset clear sequencer.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1,
  output logic                  busy
);

  typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] clear_ptr_r;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  acc0_r;
  logic                  web0_r;
  logic [NUM_WMASKS-1:0] wmask0_r;
  logic [ADDR_WIDTH-1:0] addr0_r;
  logic [DATA_WIDTH-1:0] din0_r;
  logic                  acc1_r;
  logic [ADDR_WIDTH-1:0] addr1_r;

  // Clear sequencer: walks every address once after reset, then parks in READY
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_r     <= CLEAR;
      clear_ptr_r <= {ADDR_WIDTH{1'b0}};
      busy        <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clear_ptr_r == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            state_r     <= READY;
            busy        <= 1'b0;
            clear_ptr_r <= {ADDR_WIDTH{1'b0}};
          end else begin
            clear_ptr_r <= clear_ptr_r + ADDR_WIDTH'(1);
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state_r     <= CLEAR;
          clear_ptr_r <= {ADDR_WIDTH{1'b0}};
          busy        <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: capture both port requests; acceptance uses busy as seen before this edge
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      acc0_r   <= 1'b0;
      web0_r   <= 1'b1;
      wmask0_r <= {NUM_WMASKS{1'b0}};
      addr0_r  <= {ADDR_WIDTH{1'b0}};
      din0_r   <= {DATA_WIDTH{1'b0}};
      acc1_r   <= 1'b0;
      addr1_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      acc0_r   <= ~csb0 & ~busy;
      web0_r   <= web0;
      wmask0_r <= wmask0;
      addr0_r  <= addr0;
      din0_r   <= din0;
      acc1_r   <= ~csb1 & ~busy;
      addr1_r  <= addr1;
    end
  end

  // Array update: clear writes while sequencing, otherwise masked port 0 writes
  always_ff @(posedge clk0) begin
    if (state_r == CLEAR) begin
      mem[clear_ptr_r] <= {DATA_WIDTH{1'b0}};
    end else if (acc0_r && !web0_r) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0_r[i]) begin
          mem[addr0_r][8*i +: 8] <= din0_r[8*i +: 8];
        end
      end
    end
  end

  // Stage 2 reads: non-blocking array access gives read-before-write on collisions
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0   <= {DATA_WIDTH{1'b0}};
      rvalid0 <= 1'b0;
      dout1   <= {DATA_WIDTH{1'b0}};
      rvalid1 <= 1'b0;
    end else begin
      if (acc0_r && web0_r) begin
        dout0   <= mem[addr0_r];
        rvalid0 <= 1'b1;
      end else begin
        rvalid0 <= 1'b0;
      end
      if (acc1_r) begin
        dout1   <= mem[addr1_r];
        rvalid1 <= 1'b1;
      end else begin
        rvalid1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Self-checking bench for sram_1rw1r_param: directed scenarios plus random traffic,
// compared every cycle against an array-based reference of the memory contents.
module tb_sram_1rw1r_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NM    = 4;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          csb0, web0, csb1;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, dout0, dout1;
  logic          rvalid0, rvalid1, busy;

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk0(clk0), .rst0(rst0),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .rvalid0(rvalid0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1), .rvalid1(rvalid1),
    .busy(busy)
  );

  always #5 clk0 = ~clk0;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: memory contents, requests in flight, expected outputs
  logic [DW-1:0] mm [DEPTH];
  int            clear_left;
  logic          p0_v, p0_we, p1_v;
  logic [AW-1:0] p0_a, p1_a;
  logic [DW-1:0] p0_d;
  logic [NM-1:0] p0_m;
  logic [DW-1:0] e_d0, e_d1;
  logic          e_v0, e_v1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".dout0"}, dout0, e_d0);
    chk({where, ".rvalid0"}, DW'(rvalid0), DW'(e_v0));
    chk({where, ".dout1"}, dout1, e_d1);
    chk({where, ".rvalid1"}, DW'(rvalid1), DW'(e_v1));
    chk({where, ".busy"}, DW'(busy), DW'(clear_left != 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    clear_left = DEPTH;
    p0_v = 1'b0; p0_we = 1'b0; p1_v = 1'b0;
    e_d0 = '0; e_d1 = '0; e_v0 = 1'b0; e_v1 = 1'b0;
  endtask

  // One clock: drive request, advance reference across the edge, check outputs
  task automatic step(input logic c0, input logic w0, input logic [NM-1:0] m0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic c1, input logic [AW-1:0] a1);
    logic busy_before;
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
    csb1 = c1; addr1 = a1;
    @(posedge clk0);
    e_v1 = p1_v;
    if (p1_v) e_d1 = mm[p1_a];
    e_v0 = p0_v && !p0_we;
    if (e_v0) e_d0 = mm[p0_a];
    if (p0_v && p0_we)
      for (int i = 0; i < NM; i++)
        if (p0_m[i]) mm[p0_a][8*i +: 8] = p0_d[8*i +: 8];
    busy_before = (clear_left != 0);
    p0_v = !c0 && !busy_before; p0_we = !w0; p0_a = a0; p0_d = d0; p0_m = m0;
    p1_v = !c1 && !busy_before; p1_a = a1;
    if (clear_left != 0) clear_left--;
    #1;
    check_outputs("step");
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0);
  endtask

  // Assert reset between edges: outputs must drop asynchronously, then hold two edges
  task automatic reset_pulse();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    rst0 = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk0);
    @(posedge clk0);
    #1;
    check_outputs("reset_hold");
    rst0 = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst0 = 1'b1;
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    #2;
    reset_pulse();

    // Clear phase with a write attempt that must be dropped
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) step(1'b0, 1'b0, 4'hF, 4'd2, 32'hDEADBEEF, 1'b1, 4'd0);
      else if (i == DEPTH - 1) step(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'd2);
      else idle();
      chk("busy_during_clear", DW'(busy), DW'(i < DEPTH - 1));
    end
    idle();
    chk("no_read_at_busy_fall", DW'(rvalid0 | rvalid1), 32'd0);

    // Every address reads zero through port 1; port 0 also reads the dropped-write address
    step(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'd0);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, AW'(i));
      chk("clear_zero", dout1, 32'h0);
      chk("clear_rvalid1", DW'(rvalid1), 32'd1);
    end
    idle();
    chk("drop_addr2", dout0, 32'h0);

    // Masked write merge
    step(1'b0, 1'b0, 4'b1111, 4'd5, 32'hAABBCCDD, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'b0101, 4'd5, 32'h11223344, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'b0000, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd0);
    chk("zero_mask_no_strobe", DW'(rvalid0), 32'd0);
    step(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'd0);
    idle();
    chk("masked_merge", dout0, 32'hAA22CC44);

    // Same-cycle collision: port 1 sees old data, then new
    step(1'b0, 1'b0, 4'hF, 4'd3, 32'h000000FF, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'hF, 4'd3, 32'h12345678, 1'b0, 4'd3);
    step(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd3);
    chk("collision_old", dout1, 32'h000000FF);
    idle();
    chk("collision_new", dout1, 32'h12345678);

    // Dual streaming: port 1 trails port 0 writes by one cycle
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 4'hF, AW'(i), DW'(i), (i == 0) ? 1'b1 : 1'b0, AW'(i - 1));
      if (i >= 2) begin
        chk("stream_data", dout1, DW'(i - 2));
        chk("stream_rvalid1", DW'(rvalid1), 32'd1);
      end
    end
    step(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd15);
    idle();
    chk("stream_last", dout1, 32'd15);

    // Random traffic on both ports
    for (int n = 0; n < 300; n++) begin
      rd = $urandom;
      step(1'(($urandom_range(0, 3) == 0)), 1'($urandom_range(0, 1)),
           NM'($urandom_range(0, 15)), AW'($urandom_range(0, DEPTH - 1)), rd,
           1'(($urandom_range(0, 3) == 0)), AW'($urandom_range(0, DEPTH - 1)));
    end
    idle();
    idle();

    // Reset mid-clear at pointer 7: full clear length again
    reset_pulse();
    for (int i = 0; i < 7; i++) idle();
    reset_pulse();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      chk("restart_busy", DW'(busy), DW'(i < DEPTH - 1));
    end

    // Reset while a read is in flight, with non-zero data on both outputs
    step(1'b0, 1'b0, 4'hF, 4'd9, 32'h5A5A1234, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'd9);
    step(1'b0, 1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'd9);
    chk("pre_reset_dout0", dout0, 32'h5A5A1234);
    reset_pulse();
    chk("reset_dout0", dout0, 32'h0);
    chk("reset_dout1", dout1, 32'h0);
    for (int i = 0; i < DEPTH; i++) idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
